// File: rtl/halfband_pkg.sv
// Shared definitions for the parametrised 2x halfband interpolator:
// mode encodings, width helpers and the default coefficient set.
package halfband_pkg;

  typedef enum logic [1:0] {
    MODE_FILT   = 2'b00,
    MODE_ZSTUFF = 2'b01,
    MODE_HOLD   = 2'b10
  } hb_mode_e;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_COEF_W = 18;
  localparam int DEF_N_SIDE = 2;

  // k=0 (innermost pair) occupies the low COEF_W bits.
  localparam logic [DEF_N_SIDE*DEF_COEF_W-1:0] DEF_COEFS = {-18'sd9220, 18'sd74920};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int n_side);
    return data_w + coef_w + 1 + clog2(n_side);
  endfunction

endpackage

// File: rtl/hb_round_sat.sv
// Round-half-up of a fixed-point accumulator by FRAC_W bits, then saturate
// to a signed DATA_W result with a clip flag.
module hb_round_sat
  import halfband_pkg::*;
#(
  parameter int ACC_W  = 38,
  parameter int DATA_W = 18,
  parameter int FRAC_W = 18
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y,
  output logic                     clip
);

  // One guard bit keeps the rounding bias from overflowing the accumulator.
  localparam int EXT_W = ACC_W + 1;
  localparam int R_W   = EXT_W - FRAC_W;
  localparam longint LIM = longint'(1) <<< (DATA_W - 1);
  localparam logic signed [R_W-1:0] MAX_R = R_W'(LIM - 1);
  localparam logic signed [R_W-1:0] MIN_R = R_W'(-LIM);

  function automatic logic signed [R_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] biased;
    biased = EXT_W'(a) + (EXT_W'(1) <<< (FRAC_W - 1));
    return biased[EXT_W-1:FRAC_W];
  endfunction

  // Returns {clip, value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [R_W-1:0] r);
    if (r > MAX_R) return {1'b1, MAX_R[DATA_W-1:0]};
    if (r < MIN_R) return {1'b1, MIN_R[DATA_W-1:0]};
    return {1'b0, r[DATA_W-1:0]};
  endfunction

  logic signed [R_W-1:0] rnd;

  assign rnd       = round_half_up(acc);
  assign {clip, y} = saturate(rnd);

endmodule

// File: rtl/halfband_interp2_param.sv
// 2x halfband interpolator: alternates a pass-through center tap with a
// symmetric FIR phase, with zero-stuff and sample-hold bypass modes.
module halfband_interp2_param
  import halfband_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int N_SIDE = DEF_N_SIDE,
  parameter logic [N_SIDE*COEF_W-1:0] COEFS = DEF_COEFS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic                     out_en,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid,
  output logic                     sat
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, N_SIDE);
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int TAPS   = 2 * N_SIDE;

  logic signed [DATA_W-1:0] x_dly [TAPS];
  logic                     ph;
  logic signed [ACC_W-1:0]  prod [N_SIDE];
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [DATA_W-1:0] fir_y;
  logic                     fir_clip;
  logic signed [DATA_W-1:0] y_next;
  logic                     sat_next;
  logic                     center;
  logic                     strobe;

  // Symmetric pre-add and multiply per coefficient pair, full precision.
  for (genvar k = 0; k < N_SIDE; k++) begin : g_tap
    logic signed [COEF_W-1:0] c;
    logic signed [DATA_W:0]   pre;
    logic signed [PROD_W-1:0] mul;

    assign c       = COEFS[k*COEF_W +: COEF_W];
    assign pre     = {x_dly[N_SIDE-1-k][DATA_W-1], x_dly[N_SIDE-1-k]}
                   + {x_dly[N_SIDE+k][DATA_W-1], x_dly[N_SIDE+k]};
    assign mul     = PROD_W'(pre) * PROD_W'(c);
    assign prod[k] = ACC_W'(mul);
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < N_SIDE; k++) acc_sum = acc_sum + prod[k];
  end

  hb_round_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (COEF_W)
  ) u_round_sat (
    .acc  (acc_sum),
    .y    (fir_y),
    .clip (fir_clip)
  );

  // An in_en always lands on the center phase; otherwise ph=1 selects FIR.
  assign strobe = in_en | out_en;
  assign center = in_en | ~ph;

  always_comb begin
    y_next   = y;
    sat_next = 1'b0;
    case (mode)
      MODE_ZSTUFF: y_next = center ? x_dly[0] : '0;
      MODE_HOLD:   y_next = x_dly[0];
      default: begin
        if (center) begin
          y_next = x_dly[N_SIDE-1] >>> 1;
        end else begin
          y_next   = fir_y;
          sat_next = fir_clip;
        end
      end
    endcase
  end

  // Stage boundary: delay line, phase and registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x_dly[i] <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
      ph      <= 1'b0;
    end else begin
      if (in_en) begin
        x_dly[0] <= x_in;
        for (int i = 1; i < TAPS; i++) x_dly[i] <= x_dly[i-1];
      end
      y_valid <= strobe;
      sat     <= strobe & sat_next;
      if (strobe) begin
        y  <= y_next;
        ph <= in_en ? 1'b1 : ~ph;
      end
    end
  end

endmodule

// File: tb/tb_halfband_interp2_param.sv
// Scoreboard bench: two interpolators (default and extreme coefficients) share
// stimulus; a sample-history reference model predicts every output.
module tb_halfband_interp2_param;

  localparam int DW = 18;
  localparam int CW = 18;
  localparam int NS = 2;
  localparam longint MAXD = 131071;
  localparam longint MIND = -131072;
  localparam logic [NS*CW-1:0] COEFS_B = {18'h20000, 18'h1FFFF};

  typedef struct packed {
    longint y;
    bit     sat;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 in_en;
  logic                 out_en;
  logic [1:0]           mode;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_a, y_b;
  logic                 yv_a, yv_b, sat_a, sat_b;

  halfband_interp2_param dut_a (
    .clk(clk), .reset(reset), .in_en(in_en), .out_en(out_en), .mode(mode),
    .x_in(x_in), .y(y_a), .y_valid(yv_a), .sat(sat_a)
  );

  halfband_interp2_param #(.COEFS(COEFS_B)) dut_b (
    .clk(clk), .reset(reset), .in_en(in_en), .out_en(out_en), .mode(mode),
    .x_in(x_in), .y(y_b), .y_valid(yv_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Reference state: the last 2*NS input samples (hist[0] newest) and
  // whether the previous output was a center sample.
  longint hist[2*NS];
  bit     last_center;
  longint coef_a[NS] = '{74920, -9220};
  longint coef_b[NS] = '{131071, -131072};

  function automatic exp_t ref_out(input longint c[NS], input bit ctr, input logic [1:0] m);
    exp_t   e;
    longint acc, r;
    e.sat = 1'b0;
    e.y   = 0;
    if (m == 2'b01) begin
      e.y = ctr ? hist[0] : 0;
    end else if (m == 2'b10) begin
      e.y = hist[0];
    end else if (ctr) begin
      e.y = hist[NS-1] >>> 1;
    end else begin
      acc = 0;
      for (int k = 0; k < NS; k++) acc += c[k] * (hist[NS-1-k] + hist[NS+k]);
      r = (acc + (longint'(1) <<< (CW - 1))) >>> CW;
      if (r > MAXD) begin
        e.y = MAXD; e.sat = 1'b1;
      end else if (r < MIND) begin
        e.y = MIND; e.sat = 1'b1;
      end else begin
        e.y = r;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2*NS; i++) hist[i] = 0;
    last_center = 1'b0;
  endtask

  task automatic model_step(input bit ie, input bit oe, input logic [1:0] m, input longint xv);
    bit ctr;
    if (ie || oe) begin
      ctr = ie || !last_center;
      qa.push_back(ref_out(coef_a, ctr, m));
      qb.push_back(ref_out(coef_b, ctr, m));
      last_center = ctr;
    end
    if (ie) begin
      for (int i = 2*NS-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = xv;
    end
  endtask

  task automatic step(input bit ie, input bit oe, input logic [1:0] m, input longint xv);
    in_en  = ie;
    out_en = oe;
    mode   = m;
    x_in   = xv[DW-1:0];
    model_step(ie, oe, m, xv);
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [1:0] m, input longint xv);
    step(1'b1, 1'b1, m, xv);
    step(1'b0, 1'b1, m, 0);
  endtask

  task automatic cmp(input string nm, input logic signed [DW-1:0] yy, input logic s,
                     input bit have, input exp_t e);
    n_chk++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s_extra_valid: y=%0d sat=%b, required no output pending", nm, yy, s);
    end else if ($isunknown({yy, s}) || longint'(yy) != e.y || s !== e.sat) begin
      n_fail++;
      $display("FAIL %s_out: got y=%0d sat=%b, required y=%0d sat=%b", nm, yy, s, e.y, e.sat);
    end
  endtask

  task automatic chk_reset(input string nm, input logic signed [DW-1:0] yy, input logic v, input logic s);
    n_chk++;
    if ({yy, v, s} !== '0) begin
      n_fail++;
      $display("FAIL %s_reset: got y=%0d y_valid=%b sat=%b, required all 0", nm, yy, v, s);
    end
  endtask

  task automatic chk_empty(input string nm, input int sz);
    n_chk++;
    if (sz != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected outputs never appeared, required 0", nm, sz);
    end
  endtask

  // Monitor: pops one expectation per presented output.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (yv_a === 1'b1) begin
      have = qa.size() > 0;
      e = '0;
      if (have) e = qa.pop_front();
      cmp("dut_a", y_a, sat_a, have, e);
    end else if (yv_a === 1'b0) begin
      n_chk++;
      if (sat_a !== 1'b0) begin
        n_fail++;
        $display("FAIL dut_a_idle_sat: got sat=%b, required 0", sat_a);
      end
    end
    if (yv_b === 1'b1) begin
      have = qb.size() > 0;
      e = '0;
      if (have) e = qb.pop_front();
      cmp("dut_b", y_b, sat_b, have, e);
    end else if (yv_b === 1'b0) begin
      n_chk++;
      if (sat_b !== 1'b0) begin
        n_fail++;
        $display("FAIL dut_b_idle_sat: got sat=%b, required 0", sat_b);
      end
    end
  end

  task automatic impulse_run();
    pair(2'b00, 65536);
    for (int i = 0; i < 6; i++) pair(2'b00, 0);
  endtask

  initial begin
    logic signed [DW-1:0] rv;
    longint xv;
    int r;
    logic [1:0] m;

    reset = 1'b1; in_en = 1'b0; out_en = 1'b0; mode = 2'b00; x_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("dut_a", y_a, yv_a, sat_a);
    chk_reset("dut_b", y_b, yv_b, sat_b);
    reset = 1'b0;

    impulse_run();

    for (int i = 0; i < 5; i++) pair(2'b00, -131072);

    pair(2'b00, -131072);
    pair(2'b00, 131071);
    pair(2'b00, 131071);
    pair(2'b00, -131072);
    pair(2'b00, 0);

    pair(2'b01, 1000);
    pair(2'b01, 2000);
    pair(2'b01, 0);
    pair(2'b10, 1000);
    pair(2'b10, 2000);
    pair(2'b10, 0);
    pair(2'b11, 50000);
    pair(2'b11, -70000);

    // Dropped in_en: output keeps alternating, then resyncs on the next in_en.
    pair(2'b00, 12345);
    step(1'b0, 1'b1, 2'b00, 0);
    step(1'b0, 1'b1, 2'b00, 0);
    pair(2'b00, -54321);
    step(1'b1, 1'b0, 2'b00, 777);
    step(1'b0, 1'b0, 2'b00, 0);
    step(1'b0, 1'b1, 2'b00, 0);

    for (int i = 0; i < 400; i++) begin
      rv = DW'($urandom);
      xv = rv;
      if ($urandom_range(0, 7) == 0) xv = $urandom_range(0, 1) ? MAXD : MIND;
      m = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'(($urandom_range(0, 3)));
      r = $urandom_range(0, 15);
      if (r == 0)      step(1'b0, 1'b1, m, 0);
      else if (r == 1) step(1'b1, 1'b0, m, xv);
      else if (r == 2) step(1'b0, 1'b0, m, 0);
      else             pair(m, xv);
    end

    // Mid-stream reset right after a strobe.
    pair(2'b00, 99999);
    step(1'b1, 1'b1, 2'b00, -88888);
    reset = 1'b1; in_en = 1'b0; out_en = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("dut_a", y_a, yv_a, sat_a);
    chk_reset("dut_b", y_b, yv_b, sat_b);
    chk_empty("dut_a_at_reset", qa.size());
    chk_empty("dut_b_at_reset", qb.size());
    model_reset();
    reset = 1'b0;

    impulse_run();

    repeat (3) step(1'b0, 1'b0, 2'b00, 0);
    chk_empty("dut_a", qa.size());
    chk_empty("dut_b", qb.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
